// File: rtl/pc_redirect_unit_pkg.sv
// Shared encodings and constants for the fetch PC redirect stage.
// Optional performance counters are enabled with PC_REDIRECT_PERF_EN.
`ifndef PC_REDIRECT_UNIT_PKG_DEFINES
`define PC_REDIRECT_UNIT_PKG_DEFINES
`define PCU_RUN    1'b0
`define PCU_HALT   1'b1
`define PCU_PC_INC 32'd4
`endif

package pc_redirect_unit_pkg;

    typedef enum logic {
        PcuRun  = `PCU_RUN,
        PcuHalt = `PCU_HALT
    } pcu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_unit_pc_reg.sv
// 32-bit PC register with synchronous reset and load enable.
module pc_redirect_unit_pc_reg #(
    parameter logic [31:0] ResetVal = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= ResetVal;
        end else if (en_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC stage: sequential advance, EX-resolved redirects with IF/ID and ID/EX squash, stall
// and sticky halt. Defining PC_REDIRECT_PERF_EN adds redirect and stall counters.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_taken_i,
    input  logic        jump_i,
    input  logic [31:0] target_i,
    input  logic        stall_i,
    input  logic        halt_req_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        halted_o,
`ifdef PC_REDIRECT_PERF_EN
    output logic [31:0] redirect_cnt_o,
    output logic [31:0] stall_cnt_o,
`endif
    output logic        misalign_o
);

    pcu_state_e  state_q;
    logic        halted_q;
    logic        misalign_q;
    logic        run;
    logic        redirect;
    logic        pc_en;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;

    assign run      = (state_q == PcuRun);
    assign redirect = (branch_taken_i | jump_i) & run;
    assign pc_plus4 = pc_q + `PCU_PC_INC;

    always_comb begin
        pc_d  = pc_plus4;
        pc_en = 1'b0;
        if (run) begin
            if (redirect) begin
                pc_d  = target_i;
                pc_en = 1'b1;
            end else if (!halt_req_i && !stall_i) begin
                pc_en = 1'b1;
            end
        end
    end

    pc_redirect_unit_pc_reg #(
        .ResetVal(RESET_PC)
    ) u_pc_reg (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i (pc_en),
        .d_i  (pc_d),
        .q_o  (pc_q)
    );

    // A halt request that coincides with a redirect belongs to the wrong path and is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= PcuRun;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                PcuRun: begin
                    if (redirect) begin
                        if (target_i[1]) begin
                            misalign_q <= 1'b1;
                        end
                    end else if (halt_req_i) begin
                        state_q  <= PcuHalt;
                        halted_q <= 1'b1;
                    end
                end
                PcuHalt: begin
                    state_q  <= PcuHalt;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= PcuRun;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_REDIRECT_PERF_EN
    logic [31:0] redirect_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redirect_cnt_q <= 32'd0;
            stall_cnt_q    <= 32'd0;
        end else if (run) begin
            if (redirect) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end else if (stall_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign redirect_cnt_o = redirect_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;
`endif

    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;
    assign flush_if_id_o = !rst_i & (redirect | !run);
    assign flush_id_ex_o = !rst_i & (redirect | !run);
    assign halted_o      = halted_q;
    assign misalign_o    = misalign_q;

endmodule
